rv32i_decode_stage: RTL

Pipelined RV32I instruction decoder between fetch and rename/dispatch in the out-of-order core. It accepts raw 32-bit instruction words with their PC over a valid/ready handshake. It decodes each word into register indices, a sign-extended immediate, function fields, a micro-op class and an illegal flag, using the opcode, func3 and func7 encodings of the RV32I package. A two-entry skid buffer keeps throughput at one instruction per cycle under backpressure, and flush support allows redirects.

---
 rtl/rv32i_decode_stage.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a micro-op,
// held in an output register (slot A) backed by a one-entry skid register (slot B).
module rv32i_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_class,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rd_we,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic [2:0]      out_func3,
  output logic            out_alt,
  output logic [31:0]     out_imm,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BCOND  = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_HINT   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] CLS_ALU_R   = 4'd0;
  localparam logic [3:0] CLS_ALU_I   = 4'd1;
  localparam logic [3:0] CLS_LOAD    = 4'd2;
  localparam logic [3:0] CLS_STORE   = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_JAL     = 4'd5;
  localparam logic [3:0] CLS_JALR    = 4'd6;
  localparam logic [3:0] CLS_LUI     = 4'd7;
  localparam logic [3:0] CLS_AUIPC   = 4'd8;
  localparam logic [3:0] CLS_FENCE   = 4'd9;
  localparam logic [3:0] CLS_ECALL   = 4'd10;
  localparam logic [3:0] CLS_EBREAK  = 4'd11;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      cls;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic [2:0]      func3;
    logic            alt;
    logic [31:0]     imm;
    logic            illegal;
  } uop_t;

  logic [6:0]  opcode_s;
  logic [2:0]  func3_s;
  logic [6:0]  func7_s;
  logic        func7_std_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [3:0]  cls_s;
  logic [31:0] imm_s;
  logic        ill_s, alt_s, rd_wr_s, rs1_use_s, rs2_use_s;
  uop_t        dec_s;
  uop_t        slot_a_r, slot_b_r;
  logic        a_valid_r, b_valid_r;
  logic        accept_s, consume_s;

  assign opcode_s    = in_instr[6:0];
  assign func3_s     = in_instr[14:12];
  assign func7_s     = in_instr[31:25];
  assign func7_std_s = (func7_s == 7'b0000000) || (func7_s == 7'b0100000);

  assign imm_i_s = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u_s = {in_instr[31:12], 12'h000};
  assign imm_j_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // Classify the opcode, pick the immediate format and flag illegal encodings.
  always_comb begin
    cls_s     = CLS_ILLEGAL;
    imm_s     = 32'd0;
    ill_s     = 1'b0;
    alt_s     = 1'b0;
    rd_wr_s   = 1'b0;
    rs1_use_s = 1'b0;
    rs2_use_s = 1'b0;
    case (opcode_s)
      OP_LUI:   begin cls_s = CLS_LUI;   imm_s = imm_u_s; rd_wr_s = 1'b1; end
      OP_AUIPC: begin cls_s = CLS_AUIPC; imm_s = imm_u_s; rd_wr_s = 1'b1; end
      OP_JAL:   begin cls_s = CLS_JAL;   imm_s = imm_j_s; rd_wr_s = 1'b1; end
      OP_JALR: begin
        cls_s = CLS_JALR; imm_s = imm_i_s; rd_wr_s = 1'b1; rs1_use_s = 1'b1;
        ill_s = (func3_s != 3'b000);
      end
      OP_BCOND: begin
        cls_s = CLS_BRANCH; imm_s = imm_b_s; rs1_use_s = 1'b1; rs2_use_s = 1'b1;
        ill_s = (func3_s == 3'b010) || (func3_s == 3'b011);
      end
      OP_LOAD: begin
        cls_s = CLS_LOAD; imm_s = imm_i_s; rd_wr_s = 1'b1; rs1_use_s = 1'b1;
        ill_s = (func3_s == 3'b011) || (func3_s == 3'b110) || (func3_s == 3'b111);
      end
      OP_STORE: begin
        cls_s = CLS_STORE; imm_s = imm_s_s; rs1_use_s = 1'b1; rs2_use_s = 1'b1;
        ill_s = (func3_s > 3'b010);
      end
      OP_ITYPE: begin
        cls_s = CLS_ALU_I; imm_s = imm_i_s; rd_wr_s = 1'b1; rs1_use_s = 1'b1;
        if (func3_s == 3'b001) begin
          ill_s = (func7_s != 7'b0000000);
        end else if (func3_s == 3'b101) begin
          ill_s = !func7_std_s;
          alt_s = in_instr[30];
        end else begin
          ill_s = 1'b0;
        end
      end
      OP_RTYPE: begin
        cls_s = CLS_ALU_R; rd_wr_s = 1'b1; rs1_use_s = 1'b1; rs2_use_s = 1'b1;
        alt_s = in_instr[30];
        ill_s = !func7_std_s ||
                ((func7_s == 7'b0100000) && (func3_s != 3'b000) && (func3_s != 3'b101));
      end
      OP_HINT: cls_s = CLS_FENCE;
      OP_SYSTEM: begin
        if (in_instr == 32'h0000_0073) begin
          cls_s = CLS_ECALL;
        end else if (in_instr == 32'h0010_0073) begin
          cls_s = CLS_EBREAK;
        end else begin
          ill_s = 1'b1;
        end
      end
      default: ill_s = 1'b1;
    endcase
  end

  // Assemble the micro-op; an illegal word keeps only pc and func3.
  always_comb begin
    dec_s       = '0;
    dec_s.pc    = in_pc;
    dec_s.func3 = func3_s;
    if (ill_s) begin
      dec_s.cls     = CLS_ILLEGAL;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.cls      = cls_s;
      dec_s.imm      = imm_s;
      dec_s.alt      = alt_s;
      dec_s.rd_we    = rd_wr_s && (in_instr[11:7] != 5'd0);
      dec_s.rs1_used = rs1_use_s;
      dec_s.rs2_used = rs2_use_s;
      dec_s.rd       = (rd_wr_s && (in_instr[11:7] != 5'd0)) ? in_instr[11:7] : 5'd0;
      dec_s.rs1      = rs1_use_s ? in_instr[19:15] : 5'd0;
      dec_s.rs2      = rs2_use_s ? in_instr[24:20] : 5'd0;
    end
  end

  assign accept_s  = in_valid && !b_valid_r;
  assign consume_s = a_valid_r && out_ready;

  // Slot A feeds the outputs; slot B only fills when A is held, so order is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_r <= 1'b0;
      b_valid_r <= 1'b0;
      slot_a_r  <= '0;
      slot_b_r  <= '0;
    end else if (flush) begin
      a_valid_r <= 1'b0;
      b_valid_r <= 1'b0;
    end else if (consume_s) begin
      if (b_valid_r) begin
        slot_a_r  <= slot_b_r;
        a_valid_r <= 1'b1;
        b_valid_r <= accept_s;
        if (accept_s) slot_b_r <= dec_s;
      end else begin
        a_valid_r <= accept_s;
        if (accept_s) slot_a_r <= dec_s;
      end
    end else if (accept_s) begin
      if (!a_valid_r) begin
        slot_a_r  <= dec_s;
        a_valid_r <= 1'b1;
      end else begin
        slot_b_r  <= dec_s;
        b_valid_r <= 1'b1;
      end
    end
  end

  assign in_ready     = !b_valid_r;
  assign out_valid    = a_valid_r;
  assign out_pc       = slot_a_r.pc;
  assign out_class    = slot_a_r.cls;
  assign out_rd       = slot_a_r.rd;
  assign out_rs1      = slot_a_r.rs1;
  assign out_rs2      = slot_a_r.rs2;
  assign out_rd_we    = slot_a_r.rd_we;
  assign out_rs1_used = slot_a_r.rs1_used;
  assign out_rs2_used = slot_a_r.rs2_used;
  assign out_func3    = slot_a_r.func3;
  assign out_alt      = slot_a_r.alt;
  assign out_imm      = slot_a_r.imm;
  assign out_illegal  = slot_a_r.illegal;

endmodule
